// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_pkg                                                       |
// | Brief    : Shared opcode, ALU, load-source, state and control types.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_LOAD  = 4'h4;
    localparam logic [3:0] OP_STORE = 4'h5;
    localparam logic [3:0] OP_PUSH  = 4'h6;
    localparam logic [3:0] OP_PLOT  = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [3:0] ALU_OP_NONE = 4'd0;
    localparam logic [3:0] ALU_OP_ADD  = 4'd1;
    localparam logic [3:0] ALU_OP_SUB  = 4'd2;

    localparam logic [1:0] LOAD_SRC_NONE = 2'b00;
    localparam logic [1:0] LOAD_SRC_ALU  = 2'b01;
    localparam logic [1:0] LOAD_SRC_MEM  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_EXEC      = 3'd1,
        ST_WB        = 3'd2,
        ST_PLOT_WAIT = 3'd3,
        ST_HALT      = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    typedef struct packed {
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       is_nop;
        logic       is_add;
        logic       is_sub;
        logic       is_addi;
        logic       is_load;
        logic       is_store;
        logic       is_push;
        logic       is_plot;
        logic       is_halt;
        logic       is_illegal;
    } decode_t;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [3:0]  alu_a_select;
        logic [3:0]  alu_b_select;
        logic [3:0]  alu_out_select;
        logic [3:0]  vga_color_select;
        logic [3:0]  vga_coord_select;
        logic [15:0] alu_a_altern;
        logic [15:0] alu_b_altern;
        logic        alu_a_source;
        logic        alu_b_source;
        logic [1:0]  alu_load_src;
        logic        alu_store_to_mem;
        logic        alu_store_to_stk;
        logic        pc_inc;
        logic        plot;
        logic        halted;
        logic        fault;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_unit_if                                               |
// | Brief    : Control unit <-> datapath/VGA bundle.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface control_unit_if;
    logic [15:0] current_instruction;
    logic [15:0] errorbit;
    logic        plot_ready;
    logic [3:0]  alu_op;
    logic [3:0]  alu_a_select;
    logic [3:0]  alu_b_select;
    logic [3:0]  alu_out_select;
    logic [3:0]  vga_color_select;
    logic [3:0]  vga_coord_select;
    logic [15:0] alu_a_altern;
    logic [15:0] alu_b_altern;
    logic        alu_a_source;
    logic        alu_b_source;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem;
    logic        alu_store_to_stk;
    logic        program_counter_increment;
    logic        plot;
    logic        halted;
    logic        fault;

    modport master (
        input  current_instruction, errorbit, plot_ready,
        output alu_op, alu_a_select, alu_b_select, alu_out_select,
               vga_color_select, vga_coord_select, alu_a_altern, alu_b_altern,
               alu_a_source, alu_b_source, alu_load_src, alu_store_to_mem,
               alu_store_to_stk, program_counter_increment, plot, halted, fault
    );

    modport slave (
        output current_instruction, errorbit, plot_ready,
        input  alu_op, alu_a_select, alu_b_select, alu_out_select,
               vga_color_select, vga_coord_select, alu_a_altern, alu_b_altern,
               alu_a_source, alu_b_source, alu_load_src, alu_store_to_mem,
               alu_store_to_stk, program_counter_increment, plot, halted, fault
    );
endinterface
`default_nettype wire

// File: rtl/control_unit_instr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_decode                                                  |
// | Brief    : Splits the instruction word into fields and opcode classes.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_decode
    import cpu_pkg::*;
(
    input  wire [15:0] i_instr,
    output decode_t    o_dec
);

    always_comb begin
        o_dec    = '0;
        o_dec.rd = i_instr[11:8];
        o_dec.ra = i_instr[7:4];
        o_dec.rb = i_instr[3:0];
        case (i_instr[15:12])
            OP_NOP:   o_dec.is_nop   = 1'b1;
            OP_ADD:   o_dec.is_add   = 1'b1;
            OP_SUB:   o_dec.is_sub   = 1'b1;
            OP_ADDI:  o_dec.is_addi  = 1'b1;
            OP_LOAD:  o_dec.is_load  = 1'b1;
            OP_STORE: o_dec.is_store = 1'b1;
            OP_PUSH:  o_dec.is_push  = 1'b1;
            OP_PLOT:  o_dec.is_plot  = 1'b1;
            OP_HALT:  o_dec.is_halt  = 1'b1;
            default:  o_dec.is_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_unit                                                  |
// | Brief    : Multi-cycle FSM sequencing fetch/exec/writeback/plot.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module control_unit
    import cpu_pkg::*;
(
    input  wire            clock,
    input  wire            reset,
    control_unit_if.master bus
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    decode_t     dec;

    // Decoding ir_d lets outputs be registered against the state being entered.
    instr_decode u_decode (
        .i_instr (ir_d),
        .o_dec   (dec)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ctrl_d  = '0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.current_instruction;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec.is_illegal)
                    state_d = ST_FAULT;
                else if (dec.is_halt)
                    state_d = ST_HALT;
                else if (dec.is_add || dec.is_sub || dec.is_addi || dec.is_load)
                    state_d = ST_WB;
                else if (dec.is_plot)
                    state_d = ST_PLOT_WAIT;
                else
                    state_d = ST_FETCH;
            end
            ST_WB:        state_d = (bus.errorbit != 16'h0000) ? ST_FAULT : ST_FETCH;
            ST_PLOT_WAIT: if (bus.plot_ready) state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            ST_FAULT:     state_d = ST_FAULT;
            default:      state_d = ST_FAULT;
        endcase

        case (state_d)
            ST_EXEC: begin
                ctrl_d.alu_a_select = dec.ra;
                ctrl_d.alu_b_select = dec.rb;
                if (dec.is_add || dec.is_addi)
                    ctrl_d.alu_op = ALU_OP_ADD;
                else if (dec.is_sub)
                    ctrl_d.alu_op = ALU_OP_SUB;
                else
                    ctrl_d.alu_op = ALU_OP_NONE;
                ctrl_d.alu_b_source     = dec.is_addi;
                ctrl_d.alu_b_altern     = dec.is_addi ? {12'h000, dec.rb} : 16'h0000;
                ctrl_d.alu_store_to_mem = dec.is_store;
                ctrl_d.alu_store_to_stk = dec.is_push;
                ctrl_d.pc_inc           = dec.is_nop | dec.is_store | dec.is_push;
            end
            ST_WB: begin
                ctrl_d.alu_out_select = dec.rd;
                ctrl_d.alu_load_src   = dec.is_load ? LOAD_SRC_MEM : LOAD_SRC_ALU;
                ctrl_d.pc_inc         = 1'b1;
            end
            ST_PLOT_WAIT: begin
                ctrl_d.vga_color_select = dec.ra;
                ctrl_d.vga_coord_select = dec.rb;
                ctrl_d.plot             = 1'b1;
            end
            ST_HALT:  ctrl_d.halted = 1'b1;
            ST_FAULT: ctrl_d.fault  = 1'b1;
            default:  ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= 16'h0000;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.alu_op           = ctrl_q.alu_op;
    assign bus.alu_a_select     = ctrl_q.alu_a_select;
    assign bus.alu_b_select     = ctrl_q.alu_b_select;
    assign bus.alu_out_select   = ctrl_q.alu_out_select;
    assign bus.vga_color_select = ctrl_q.vga_color_select;
    assign bus.vga_coord_select = ctrl_q.vga_coord_select;
    assign bus.alu_a_altern     = ctrl_q.alu_a_altern;
    assign bus.alu_b_altern     = ctrl_q.alu_b_altern;
    assign bus.alu_a_source     = ctrl_q.alu_a_source;
    assign bus.alu_b_source     = ctrl_q.alu_b_source;
    assign bus.alu_load_src     = ctrl_q.alu_load_src;
    assign bus.alu_store_to_mem = ctrl_q.alu_store_to_mem;
    assign bus.alu_store_to_stk = ctrl_q.alu_store_to_stk;
    assign bus.plot             = ctrl_q.plot;
    assign bus.halted           = ctrl_q.halted;
    assign bus.fault            = ctrl_q.fault;

    // The plot handshake retires in the ready cycle itself; a pending reset cancels it.
    assign bus.program_counter_increment = ctrl_q.pc_inc |
        ((state_q == ST_PLOT_WAIT) & bus.plot_ready & ~reset);

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port current_instruction, input, 16: instruction word at the program counter, from the datapath.
REQ-004 SHALL have port errorbit, input, 16: datapath error flags; any nonzero value means error.
REQ-005 SHALL have port plot_ready, input, 1: VGA adapter can accept a pixel.
REQ-006 SHALL have ports alu_op (4), alu_a_select (4), alu_b_select (4), alu_out_select (4), vga_color_select (4), vga_coord_select (4), all outputs: datapath selects.
REQ-007 SHALL have ports alu_a_altern and alu_b_altern, outputs, 16: immediate operands.
REQ-008 SHALL have ports alu_a_source and alu_b_source, outputs, 1: 1 selects the altern operand, 0 selects the register.
REQ-009 SHALL have port alu_load_src, output, 2: 00 none, 01 ALU result, 10 memory.
REQ-010 SHALL have ports alu_store_to_mem and alu_store_to_stk, outputs, 1: store strobes.
REQ-011 SHALL have port program_counter_increment, output, 1: one-cycle PC advance.
REQ-012 SHALL have ports plot, halted and fault, outputs, 1: pixel request, HALT reached, error stop.
REQ-013 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-014 SHALL decode the instruction fields as op=[15:12], rd=[11:8], ra=[7:4], rb/imm=[3:0].
REQ-015 SHALL support these opcodes:
- 0 NOP
- 1 ADD: rd=ra+rb
- 2 SUB: rd=ra-rb
- 3 ADDI: rd=ra+zext(imm)
- 4 LOAD: rd=mem[ra]
- 5 STORE: mem[ra]=rb
- 6 PUSH: stk<=ra
- 7 PLOT: colour reg ra, coordinate reg rb
- F HALT
REQ-016 SHALL treat opcodes 8-E as illegal and enter FAULT.
REQ-017 SHALL implement FSM states FETCH, EXEC, WB, PLOT_WAIT, HALT and FAULT; the reset state is FETCH.
REQ-018 FETCH SHALL latch current_instruction into an internal IR and go to EXEC after 1 cycle.
REQ-019 EXEC SHALL drive the ALU controls from IR:
- alu_op: 1 for ADD/ADDI, 2 for SUB, 0 otherwise
- alu_a_select=ra, alu_b_select=rb
- ADDI only: alu_b_source=1, alu_b_altern=zext(imm)
REQ-020 From EXEC, ADD/SUB/ADDI/LOAD SHALL go to WB; STORE/PUSH/NOP SHALL assert their strobe, if any, for exactly 1 cycle and pulse program_counter_increment in that same cycle, then return to FETCH.
REQ-021 WB SHALL drive:
- alu_out_select=rd
- alu_load_src=01 (arith) or 10 (LOAD), for exactly 1 cycle
- program_counter_increment=1
then go to FETCH.
REQ-022 PLOT SHALL go EXEC->PLOT_WAIT with vga_color_select=ra and vga_coord_select=rb held, plot=1 held, until a cycle with plot_ready=1; that cycle SHALL also pulse program_counter_increment, then go to FETCH.
REQ-023 If plot_ready=1 already on the first PLOT_WAIT cycle, PLOT_WAIT SHALL last exactly 1 cycle.
REQ-024 HALT opcode SHALL enter HALT; HALT SHALL be absorbing until reset, with halted=1 and no PC increment.
REQ-025 errorbit!=0 sampled in WB SHALL still complete the writeback, then enter FAULT instead of FETCH.
REQ-026 FAULT SHALL be absorbing, with fault=1 and all strobes 0.
REQ-027 Latency SHALL be:
- ALU/LOAD: 3 cycles
- STORE/PUSH/NOP: 2 cycles
- PLOT: 2+wait cycles
REQ-028 program_counter_increment SHALL pulse exactly once per retired instruction.
REQ-029 Outside their defining states, all strobes SHALL be 0, all selects 0 and alterns 0.
REQ-030 Controls SHALL be registered-state Moore outputs, not a function of the inputs, except where REQ-022 samples plot_ready.

Reset
REQ-031 reset=1 at a rising edge SHALL force FETCH, IR=0 and every output 0, including halted and fault.
REQ-032 Reset SHALL take priority over every state, including mid-PLOT_WAIT, HALT and FAULT.
REQ-033 A reset during PLOT_WAIT SHALL drop plot on the next cycle and SHALL NOT pulse program_counter_increment.

Structure
REQ-034 Opcode constants, alu_op codes, alu_load_src encodings and the state encoding SHALL live in a shared package, cpu_pkg.
REQ-035 The combinational IR field/opcode classifier SHALL be one sub-module, instr_decode; the FSM and output logic SHALL stay in control_unit.

Verification
REQ-036 ADDI: IR 16'h3702, reg7=0 -> EXEC alu_op=1, b_source=1, b_altern=2; WB alu_out_select=7, load_src=01; PC pulse after 3 cycles.
REQ-037 PLOT: IR 16'h7012, plot_ready low 4 cycles then high -> plot high 5 cycles, selects 1/2 held, single PC pulse on the ready cycle.
REQ-038 Illegal and halt: IR 16'h9000 -> fault=1 permanently with no PC pulse; IR 16'hF000 -> halted=1 with outputs stable for 20 cycles.
REQ-039 Error: ADD with errorbit=16'h0001 during WB -> load_src=01 for 1 cycle, then FAULT.
REQ-040 Reset mid-PLOT_WAIT -> all outputs 0 the following cycle, FETCH, no PC pulse; STORE 16'h5034 -> alu_store_to_mem for 1 cycle, with PC pulse in that cycle.
